// File: rtl/red_pitaya_pwm_dac.sv
// Single-channel PWM DAC with one coarse setting per period and an optional 16-period dither frame.
// Define PWM_DAC_DITHER_EN to enable dither; otherwise the frame is one period and cfg_i[15:0] is ignored.
module red_pitaya_pwm_dac #(
    parameter int unsigned PERIOD = 156,
    parameter int unsigned CW     = 8,
    parameter int unsigned FW     = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [23:0] cfg_i,
    output logic        pwm_o,
    output logic        sync_o
);
    localparam int unsigned   TW       = CW + 1;
    localparam logic [CW-1:0] VcntLast = CW'(PERIOD - 1);

    logic [CW-1:0] vcnt_q, vcnt_d;
    logic          vcnt_last;
    logic          frame_end;
    logic [TW-1:0] thr;

    assign vcnt_last = (vcnt_q == VcntLast);
    assign vcnt_d    = vcnt_last ? '0 : vcnt_q + CW'(1);

`ifdef PWM_DAC_DITHER_EN
    localparam int unsigned   BW       = $clog2(FW);
    localparam logic [BW-1:0] BcntLast = BW'(FW - 1);

    logic [23:0]   cfg_q, cfg_d;
    logic [FW-1:0] dither;
    logic [BW-1:0] bcnt_q, bcnt_d;

    assign cfg_d  = cfg_i;
    assign dither = cfg_q[FW-1:0];

    always_comb begin
        bcnt_d = bcnt_q;
        if (vcnt_last) begin
            bcnt_d = (bcnt_q == BcntLast) ? '0 : bcnt_q + BW'(1);
        end
    end

    assign frame_end = vcnt_last && (bcnt_q == BcntLast);
    // Dither bit index equals the period number within the frame.
    assign thr = TW'(cfg_q[23 -: CW]) + TW'(dither[bcnt_q]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bcnt_q <= '0;
        end else begin
            bcnt_q <= bcnt_d;
        end
    end
`else
    logic [CW-1:0] cfg_q, cfg_d;
    logic [FW-1:0] unused_dither;

    assign cfg_d         = cfg_i[23 -: CW];
    assign unused_dither = cfg_i[FW-1:0];
    assign frame_end     = vcnt_last;
    assign thr           = TW'(cfg_q);
`endif

    // Shadow register reloads on every reset cycle so release starts with the live setting.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vcnt_q <= '0;
            pwm_o  <= 1'b0;
            sync_o <= 1'b0;
            cfg_q  <= cfg_d;
        end else begin
            vcnt_q <= vcnt_d;
            pwm_o  <= ({1'b0, vcnt_q} < thr);
            sync_o <= frame_end;
            if (frame_end) begin
                cfg_q <= cfg_d;
            end
        end
    end

endmodule

// File: tb/tb_red_pitaya_pwm_dac.sv
// Scoreboard bench for red_pitaya_pwm_dac: high-cycle count and sync spacing per frame.
// Follows PWM_DAC_DITHER_EN to pick the frame length and expected counts.
module tb_red_pitaya_pwm_dac;
    localparam int PERIOD = 156;
`ifdef PWM_DAC_DITHER_EN
    localparam int FRAME_P = 16;
`else
    localparam int FRAME_P = 1;
`endif
    localparam int FR      = PERIOD * FRAME_P;
    localparam int RST_OFS = (FRAME_P > 1 ? 7 * PERIOD : 0) + 40;
    localparam int NVEC    = 12;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [23:0] cfg_i;
    logic        pwm_o;
    logic        sync_o;

    red_pitaya_pwm_dac dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .cfg_i  (cfg_i),
        .pwm_o  (pwm_o),
        .sync_o (sync_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [23:0] cfg;
        int          hi_single;
        int          hi_dither;
    } vec_t;

    typedef struct {
        int   hi;
        logic first;
    } exp_t;

    vec_t tbl [NVEC];
    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    initial begin
        // {cfg, high cycles per one-period frame, high cycles per 16-period frame}
        tbl[0]  = '{24'h000000,   0,    0};
        tbl[1]  = '{24'h4E0000,  78, 1248};
        tbl[2]  = '{24'h0A0001,  10,  161};
        tbl[3]  = '{24'h0AFFFF,  10,  176};
        tbl[4]  = '{24'h9C0000, 156, 2496};
        tbl[5]  = '{24'hFF0000, 156, 2496};
        tbl[6]  = '{24'h9BFFFF, 155, 2496};
        tbl[7]  = '{24'h9B0000, 155, 2480};
        tbl[8]  = '{24'h0F0000,  15,  240};
        tbl[9]  = '{24'h750000, 117, 1872};
        tbl[10] = '{24'h010000,   1,   16};
        tbl[11] = '{24'h000001,   0,    1};
    end

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t make_exp(input vec_t v);
        exp_t e;
        e.hi    = (FRAME_P > 1) ? v.hi_dither : v.hi_single;
        e.first = (v.cfg[23:16] != 8'd0) || ((FRAME_P > 1) && v.cfg[0]);
        return e;
    endfunction

    // Monitor: one sample per clock, attributed to the frame of the preceding edge.
    logic rst_seen = 1'b1;
    int   hi_cnt   = 0;
    int   gap      = 0;
    logic first_v  = 1'b0;

    always @(posedge clk_i) rst_seen <= rst_i;

    always @(negedge clk_i) begin
        if (rst_seen) begin
            hi_cnt = 0;
            gap    = 0;
        end else begin
            gap++;
            if (gap == 1) first_v = pwm_o;
            if (pwm_o === 1'b1) hi_cnt++;
            if (sync_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_sync", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("frame_high_count", hi_cnt, e.hi);
                    check("first_cycle_level", int'(first_v), int'(e.first));
                end
                check("sync_spacing", gap, FR);
                hi_cnt = 0;
                gap    = 0;
            end
        end
    end

    // Holds a decoy setting for the first half of the frame, then the real next one.
    task automatic run_frame(input logic [23:0] next_cfg);
        cfg_i = ~next_cfg;
        repeat (FR / 2) @(posedge clk_i);
        #1 cfg_i = next_cfg;
        repeat (FR - FR / 2) @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        cfg_i = 24'h4E0000;
        @(posedge clk_i);
        #1 cfg_i = tbl[0].cfg;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_pwm", int'(pwm_o), 0);
        check("reset_sync", int'(sync_o), 0);
        rst_i = 1'b0;

        for (int j = 0; j < NVEC; j++) begin
            exp_q.push_back(make_exp(tbl[j]));
            run_frame((j + 1 < NVEC) ? tbl[j + 1].cfg : 24'h4E0000);
        end

        // Abort a frame mid-way; its partial count must never be reported.
        cfg_i = 24'h4E0000;
        repeat (RST_OFS) @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("midframe_reset_pwm", int'(pwm_o), 0);
        check("midframe_reset_sync", int'(sync_o), 0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        exp_q.push_back(make_exp(tbl[1]));
        run_frame(24'h000000);

        repeat (3) @(posedge clk_i);
        #1;
        check("pending_frames", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
